alu_addsub_pipe: RTL and testbench

- Two-stage pipelined add/sub/compare unit for the RV32I execute path.
- Consumes register-file operands, produces ADD, SUB, SLT and SLTU results plus carry, overflow and zero flags.
- Feeds the writeback result register and the branch-compare logic.
- Valid/ready handshakes on both sides; backpressure propagates upstream.

---
 rtl/alu_addsub_pipe.sv | 143 ++++++++++++++
 tb/tb_alu_addsub_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_addsub_pipe.sv
// Two-stage pipelined add/sub/compare unit for the RV32I execute path.
// Stage 1 captures operands, stage 2 holds the computed result and flags.
// Both stages advance together when the output side can take data, so a
// full pipeline with out_ready high streams one operation per cycle.
module alu_addsub_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_zero
);

   typedef enum logic [1:0] {
      OpAdd  = 2'b00,
      OpSub  = 2'b01,
      OpSlt  = 2'b10,
      OpSltu = 2'b11
   } op_e;

   logic             s1Valid_q, s1Valid_d;
   op_e              s1Op_q, s1Op_d;
   logic [WIDTH-1:0] s1A_q, s1A_d;
   logic [WIDTH-1:0] s1B_q, s1B_d;

   logic             s2Valid_q, s2Valid_d;
   logic [WIDTH-1:0] s2Result_q, s2Result_d;
   logic             s2Carry_q, s2Carry_d;
   logic             s2Overflow_q, s2Overflow_d;
   logic             s2Zero_q, s2Zero_d;

   logic             s1Adv;
   logic             inFire;
   logic             isSub;
   logic [WIDTH-1:0] bEff;
   logic [WIDTH:0]   sum;
   logic             carry;
   logic             overflow;
   logic [WIDTH-1:0] result;

   // Stage 2 can take new data when it is empty or its content leaves now;
   // stage 1 can take operands when it is empty or it moves into stage 2.
   always_comb begin
      s1Adv    = !s2Valid_q || out_ready;
      in_ready = !s1Valid_q || s1Adv;
      inFire   = in_valid && in_ready;
   end

   // Single shared adder: subtraction and both compares use a + ~b + 1.
   always_comb begin
      isSub    = (s1Op_q != OpAdd);
      bEff     = isSub ? ~s1B_q : s1B_q;
      sum      = {1'b0, s1A_q} + {1'b0, bEff} + {{WIDTH{1'b0}}, isSub};
      carry    = sum[WIDTH];
      overflow = (s1A_q[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != s1A_q[WIDTH-1]);
      result   = sum[WIDTH-1:0];
      case (s1Op_q)
         OpSlt:   result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ overflow};
         OpSltu:  result = {{(WIDTH-1){1'b0}}, !carry};
         default: result = sum[WIDTH-1:0];
      endcase
   end

   // Next state for stage 1: load on an input transfer, empty out when the
   // held operation moves on without a replacement, otherwise hold.
   always_comb begin
      s1Valid_d = s1Valid_q;
      s1Op_d    = s1Op_q;
      s1A_d     = s1A_q;
      s1B_d     = s1B_q;
      if (inFire) begin
         s1Valid_d = 1'b1;
         s1Op_d    = op_e'(in_op);
         s1A_d     = in_a;
         s1B_d     = in_b;
      end else if (s1Adv) begin
         s1Valid_d = 1'b0;
      end
   end

   // Next state for stage 2: take the computed result when stage 1 advances;
   // data is only refreshed for a real operation so idle outputs stay quiet.
   always_comb begin
      s2Valid_d    = s2Valid_q;
      s2Result_d   = s2Result_q;
      s2Carry_d    = s2Carry_q;
      s2Overflow_d = s2Overflow_q;
      s2Zero_d     = s2Zero_q;
      if (s1Adv) begin
         s2Valid_d = s1Valid_q;
         if (s1Valid_q) begin
            s2Result_d   = result;
            s2Carry_d    = carry;
            s2Overflow_d = overflow;
            s2Zero_d     = (result == '0);
         end
      end
   end

   // Pipeline registers; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q    <= 1'b0;
         s1Op_q       <= OpAdd;
         s1A_q        <= '0;
         s1B_q        <= '0;
         s2Valid_q    <= 1'b0;
         s2Result_q   <= '0;
         s2Carry_q    <= 1'b0;
         s2Overflow_q <= 1'b0;
         s2Zero_q     <= 1'b0;
      end else begin
         s1Valid_q    <= s1Valid_d;
         s1Op_q       <= s1Op_d;
         s1A_q        <= s1A_d;
         s1B_q        <= s1B_d;
         s2Valid_q    <= s2Valid_d;
         s2Result_q   <= s2Result_d;
         s2Carry_q    <= s2Carry_d;
         s2Overflow_q <= s2Overflow_d;
         s2Zero_q     <= s2Zero_d;
      end
   end

   // Outputs come straight from the stage-2 registers.
   always_comb begin
      out_valid    = s2Valid_q;
      out_result   = s2Result_q;
      out_carry    = s2Carry_q;
      out_overflow = s2Overflow_q;
      out_zero     = s2Zero_q;
   end

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Testbench for alu_addsub_pipe: a 32-bit instance checked every cycle
// against an arithmetic reference model and an in-order expectation queue,
// plus a 4-bit instance for small hand-worked cases.
module tb_alu_addsub_pipe;

   typedef struct {
      longint unsigned res;
      bit              carry;
      bit              ovf;
      bit              zero;
      int              acceptEdge;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic        in_valid32, in_ready32, out_valid32, out_ready32;
   logic [1:0]  in_op32;
   logic [31:0] in_a32, in_b32, out_result32;
   logic        out_carry32, out_overflow32, out_zero32;

   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [1:0]  in_op4;
   logic [3:0]  in_a4, in_b4, out_result4;
   logic        out_carry4, out_overflow4, out_zero4;

   int          checks;
   int          failures;
   int          edgeCnt;
   int          inFires32;
   int          outFires32;
   exp_t        scoreboard[$];

   alu_addsub_pipe #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_op(in_op32),
      .in_a(in_a32), .in_b(in_b32),
      .out_valid(out_valid32), .out_ready(out_ready32), .out_result(out_result32),
      .out_carry(out_carry32), .out_overflow(out_overflow32), .out_zero(out_zero32)
   );

   alu_addsub_pipe #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_op(in_op4),
      .in_a(in_a4), .in_b(in_b4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_result(out_result4),
      .out_carry(out_carry4), .out_overflow(out_overflow4), .out_zero(out_zero4)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to time when an accepted operation may appear.
   always @(posedge clk) edgeCnt++;

   // Reference: plain integer arithmetic on w-bit operands.
   function automatic exp_t model(input int w, input logic [1:0] op,
                                  input longint unsigned a, input longint unsigned b);
      exp_t            e;
      longint unsigned modv;
      longint          half;
      longint          sa, sbv, s;
      longint unsigned u;
      modv = 64'd1 << w;
      half = longint'(64'd1 << (w - 1));
      sa   = (a >= longint'(half)) ? longint'(a) - longint'(modv) : longint'(a);
      sbv  = (b >= longint'(half)) ? longint'(b) - longint'(modv) : longint'(b);
      if (op == 2'b00) begin
         u       = a + b;
         s       = sa + sbv;
         e.carry = (u >= modv);
      end else begin
         u       = a + modv - b;
         s       = sa - sbv;
         e.carry = (a >= b);
      end
      e.ovf = (s < -half) || (s >= half);
      case (op)
         2'b10:   e.res = (sa < sbv) ? 64'd1 : 64'd0;
         2'b11:   e.res = (a < b) ? 64'd1 : 64'd0;
         default: e.res = u % modv;
      endcase
      e.zero       = (e.res == 0);
      e.acceptEdge = 0;
      return e;
   endfunction

   task automatic checkOutput(input string name, input longint unsigned actual,
                              input longint unsigned expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Compare process for the 32-bit unit: handshake, timing and data are
   // checked against the expectation queue on every cycle out of reset.
   always @(negedge clk) begin
      if (!rst_n) begin
         scoreboard.delete();
      end else begin
         bit   expValid;
         exp_t m;
         expValid = (scoreboard.size() > 0) && (edgeCnt >= scoreboard[0].acceptEdge + 1);
         checkOutput("in_ready", in_ready32, ((scoreboard.size() < 2) || out_ready32) ? 1 : 0);
         checkOutput("out_valid", out_valid32, expValid);
         if (out_valid32 && expValid) begin
            checkOutput("out_result", out_result32, scoreboard[0].res);
            checkOutput("out_carry", out_carry32, scoreboard[0].carry);
            checkOutput("out_overflow", out_overflow32, scoreboard[0].ovf);
            checkOutput("out_zero", out_zero32, scoreboard[0].zero);
         end
         if (out_valid32 && out_ready32) begin
            outFires32++;
            if (scoreboard.size() > 0) void'(scoreboard.pop_front());
         end
         if (in_valid32 && in_ready32) begin
            inFires32++;
            m            = model(32, in_op32, in_a32, in_b32);
            m.acceptEdge = edgeCnt + 1;
            scoreboard.push_back(m);
         end
      end
   end

   // One isolated operation on an idle unit with hand-computed expectations;
   // the result must be visible exactly two cycles after acceptance.
   task automatic applyStimulus(input bit use4, input logic [1:0] op,
                                input longint unsigned a, input longint unsigned b,
                                input longint unsigned expRes, input bit expC,
                                input bit expO, input bit expZ, input string name);
      exp_t m;
      m = model(use4 ? 4 : 32, op, a, b);
      checkOutput({name, " model result"}, m.res, expRes);
      checkOutput({name, " model flags"}, {m.carry, m.ovf, m.zero}, {expC, expO, expZ});
      @(posedge clk); #1;
      if (use4) begin
         in_valid4 = 1'b1; in_op4 = op; in_a4 = a[3:0]; in_b4 = b[3:0];
      end else begin
         in_valid32 = 1'b1; in_op32 = op; in_a32 = a[31:0]; in_b32 = b[31:0];
      end
      @(negedge clk);
      checkOutput({name, " accept"}, use4 ? in_ready4 : in_ready32, 1);
      @(posedge clk); #1;
      in_valid4  = 1'b0;
      in_valid32 = 1'b0;
      @(negedge clk);
      checkOutput({name, " not yet valid"}, use4 ? out_valid4 : out_valid32, 0);
      @(negedge clk);
      checkOutput({name, " valid at 2"}, use4 ? out_valid4 : out_valid32, 1);
      checkOutput({name, " result"}, use4 ? longint'(out_result4) : longint'(out_result32), expRes);
      checkOutput({name, " carry"}, use4 ? out_carry4 : out_carry32, expC);
      checkOutput({name, " overflow"}, use4 ? out_overflow4 : out_overflow32, expO);
      checkOutput({name, " zero"}, use4 ? out_zero4 : out_zero32, expZ);
   endtask

   task automatic driveRandom32();
      in_op32 = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
         0:       in_a32 = 32'h7FFF_FFFF;
         1:       in_a32 = 32'h8000_0000;
         default: in_a32 = $urandom;
      endcase
      in_b32 = ($urandom_range(0, 5) == 0) ? in_a32 : $urandom;
   endtask

   initial begin
      int inSnap;
      int outSnap;
      checks = 0; failures = 0; edgeCnt = 0; inFires32 = 0; outFires32 = 0;
      rst_n = 1'b0;
      in_valid32 = 1'b0; in_op32 = 2'b00; in_a32 = '0; in_b32 = '0; out_ready32 = 1'b1;
      in_valid4  = 1'b0; in_op4  = 2'b00; in_a4  = '0; in_b4  = '0; out_ready4  = 1'b1;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("reset out_valid", out_valid32, 0);
      checkOutput("reset out_result", out_result32, 0);
      checkOutput("reset flags", {out_carry32, out_overflow32, out_zero32}, 0);
      checkOutput("reset in_ready", in_ready32, 1);
      checkOutput("reset out_valid4", out_valid4, 0);
      @(posedge clk); #2 rst_n = 1'b1;

      // Hand-worked 4-bit cases.
      applyStimulus(1'b1, 2'b00, 10, 14, 8, 1'b1, 1'b0, 1'b0, "w4 add 10+14");
      applyStimulus(1'b1, 2'b10, 10, 14, 1, 1'b0, 1'b0, 1'b0, "w4 slt 10,14");
      applyStimulus(1'b1, 2'b11, 10, 14, 1, 1'b0, 1'b0, 1'b0, "w4 sltu 10,14");
      applyStimulus(1'b1, 2'b10, 3, 10, 0, 1'b0, 1'b1, 1'b1, "w4 slt 3,10");
      applyStimulus(1'b1, 2'b11, 3, 10, 1, 1'b0, 1'b1, 1'b0, "w4 sltu 3,10");

      // Hand-worked 32-bit boundary cases.
      applyStimulus(1'b0, 2'b00, 64'h7FFF_FFFF, 1, 64'h8000_0000, 1'b0, 1'b1, 1'b0, "w32 add ovf");
      applyStimulus(1'b0, 2'b01, 5, 5, 0, 1'b1, 1'b0, 1'b1, "w32 sub 5-5");
      applyStimulus(1'b0, 2'b01, 0, 1, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "w32 sub 0-1");

      // Backpressure: three back-to-back ops against a stalled output.
      @(posedge clk); #1;
      out_ready32 = 1'b0;
      inSnap = inFires32;
      in_valid32 = 1'b1;
      driveRandom32();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         if (in_ready32) begin
            @(posedge clk); #1;
            driveRandom32();
         end else begin
            @(posedge clk); #1;
         end
      end
      @(negedge clk); #1;
      checkOutput("stall accepted count", inFires32 - inSnap, 2);
      checkOutput("stall in_ready low", in_ready32, 0);
      @(posedge clk); #1;
      out_ready32 = 1'b1;
      outSnap = outFires32;
      @(negedge clk);
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      checkOutput("release delivered", outFires32 - outSnap, 3);
      checkOutput("release accepted total", inFires32 - inSnap, 3);

      // Streaming: 16 ops back to back with the output always ready.
      @(posedge clk); #1;
      inSnap  = inFires32;
      outSnap = outFires32;
      for (int i = 0; i < 16; i++) begin
         in_valid32 = 1'b1;
         driveRandom32();
         @(posedge clk); #1;
      end
      in_valid32 = 1'b0;
      checkOutput("stream accepted", inFires32 - inSnap, 16);
      @(negedge clk);
      @(negedge clk); #1;
      checkOutput("stream delivered", outFires32 - outSnap, 16);

      // Random valid/ready traffic.
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         in_valid32  = ($urandom_range(0, 3) != 0);
         out_ready32 = ($urandom_range(0, 2) != 0);
         driveRandom32();
      end
      @(posedge clk); #1;
      in_valid32  = 1'b0;
      out_ready32 = 1'b1;
      repeat (4) @(negedge clk);
      #1 checkOutput("random drained", scoreboard.size(), 0);

      // Asynchronous reset with both stages full.
      @(posedge clk); #1;
      out_ready32 = 1'b0;
      in_valid32  = 1'b1;
      driveRandom32();
      repeat (4) @(posedge clk);
      #1 in_valid32 = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset out_valid", out_valid32, 0);
      checkOutput("async reset out_result", out_result32, 0);
      checkOutput("async reset flags", {out_carry32, out_overflow32, out_zero32}, 0);
      checkOutput("async reset in_ready", in_ready32, 1);
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      out_ready32 = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(1'b0, 2'b01, 64'h0000_0010, 64'h0000_0020, 64'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, "post-reset sub");
      repeat (2) @(negedge clk);
      #1 checkOutput("final drained", scoreboard.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
